// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package serial_adder_ctrl_pkg;
    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_adder_ctrl_rca4.sv
// 4-bit ripple-carry adder slice, reused once per nibble by the controller.
module ripple_carry_adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];
endmodule

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice processes one nibble per cycle,
// carry held in a register between cycles.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int NUM_NIBBLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [SLICE_W*NUM_NIBBLES-1:0] a,
    input  logic [SLICE_W*NUM_NIBBLES-1:0] b,
    input  logic                           cin,
    output logic                           ready,
    output logic                           busy,
    output logic                           done,
    output logic [SLICE_W*NUM_NIBBLES-1:0] sum,
    output logic                           cout,
    output logic                           ovf
);
    localparam int W     = SLICE_W * NUM_NIBBLES;
    localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [SLICE_W-1:0] w_a_nib;
    logic [SLICE_W-1:0] w_b_nib;
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;
    logic               w_last;

    assign w_a_nib = r_a[SLICE_W*r_idx +: SLICE_W];
    assign w_b_nib = r_b[SLICE_W*r_idx +: SLICE_W];
    assign w_last  = (r_idx == IDX_W'(NUM_NIBBLES - 1));

    ripple_carry_adder4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    r_sum[SLICE_W*r_idx +: SLICE_W] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + 1'b1;
                    // Overflow uses the MSB being written this cycle, not the stale register.
                    if (w_last) begin
                        r_state <= DONE;
                        r_cout  <= w_slice_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) &&
                                   (w_slice_sum[SLICE_W-1] != r_a[W-1]);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;
endmodule
